// File: rtl/module_mux_pkg.sv
// module_mux_pkg: selection modes and shared widths for the round-robin mux/arbiter
package module_mux_pkg;
    localparam int MODO_W = 2;
    typedef enum logic [MODO_W-1:0] {MODO_SEL = 2'b00, MODO_PRIO = 2'b01, MODO_RR = 2'b10} modo_t;
endpackage

// File: rtl/module_arbitro_rr.sv
// module_arbitro_rr: combinational grant decision (external select, fixed priority, round-robin)
//   req       in   per-channel request
//   ptr       in   round-robin start index
//   modo      in   selection mode; 2'b11 behaves as round-robin
//   sel       in   channel index for external-select mode
//   hay_grant out  a channel is granted
//   grant_idx out  index of the granted channel
module module_arbitro_rr import module_mux_pkg::*; #(
    parameter int CANALES = 4,
    parameter int SEL_W   = $clog2(CANALES)
) (
    input  logic [CANALES-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    input  logic [MODO_W-1:0]  modo,
    input  logic [SEL_W-1:0]   sel,
    output logic               hay_grant,
    output logic [SEL_W-1:0]   grant_idx
);
    always_comb begin
        hay_grant = 1'b0;
        grant_idx = '0;
        if (modo == MODO_SEL) begin
            hay_grant = (int'(sel) < CANALES) ? req[sel] : 1'b0;
            grant_idx = sel;
        end else if (modo == MODO_PRIO) begin
            // descending scan: the last hit, i.e. the lowest index, wins
            for (int i = CANALES - 1; i >= 0; i--) begin
                if (req[i]) begin
                    hay_grant = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            // descending offset scan: the hit closest to ptr wins
            for (int k = CANALES - 1; k >= 0; k--) begin
                if (req[(int'(ptr) + k) % CANALES]) begin
                    hay_grant = 1'b1;
                    grant_idx = SEL_W'((int'(ptr) + k) % CANALES);
                end
            end
        end
    end
endmodule

// File: rtl/module_mux_arbitro_rr.sv
// module_mux_arbitro_rr: N-channel valid/ready mux with one registered output stage
//   clk, rst    clock, synchronous active-high reset
//   modo, sel   selection mode and external channel select
//   in_data     packed per-channel data; in_valid/in_ready per-channel handshake
//   out_data    registered data; out_valid/out_ready output handshake
//   out_canal   registered index of the channel that supplied out_data
module module_mux_arbitro_rr import module_mux_pkg::*; #(
    parameter int   CANALES = 4,
    parameter int   ANCHO   = 4,
    localparam int  SEL_W   = $clog2(CANALES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [MODO_W-1:0]               modo,
    input  logic [SEL_W-1:0]                sel,
    input  logic [CANALES-1:0][ANCHO-1:0]   in_data,
    input  logic [CANALES-1:0]              in_valid,
    output logic [CANALES-1:0]              in_ready,
    output logic [ANCHO-1:0]                out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SEL_W-1:0]                out_canal
);
    logic             carga;
    logic             hay_grant;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] ptr;

    module_arbitro_rr #(.CANALES(CANALES), .SEL_W(SEL_W)) u_arbitro (
        .req       (in_valid),
        .ptr       (ptr),
        .modo      (modo),
        .sel       (sel),
        .hay_grant (hay_grant),
        .grant_idx (grant_idx)
    );

    assign carga    = !out_valid || out_ready;
    assign in_ready = (!rst && carga && hay_grant) ? {{(CANALES-1){1'b0}}, 1'b1} << grant_idx : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_canal <= '0;
            ptr       <= '0;
        end else if (carga) begin
            out_valid <= hay_grant;
            if (hay_grant) begin
                out_data  <= in_data[grant_idx];
                out_canal <= grant_idx;
                ptr       <= (grant_idx == SEL_W'(CANALES - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_module_mux_arbitro_rr.sv
// tb_module_mux_arbitro_rr: scoreboard bench with an independent arbitration model
module tb_module_mux_arbitro_rr;
    import module_mux_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       modo = MODO_SEL;
    logic [1:0]       sel = '0;
    logic [3:0][3:0]  in_data = '0;
    logic [3:0]       in_valid = '0;
    logic [3:0]       in_ready;
    logic [3:0]       out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [1:0]       out_canal;

    logic [1:0]       modo3 = MODO_SEL;
    logic [1:0]       sel3 = '0;
    logic [2:0][3:0]  in_data3 = {4'h7, 4'h6, 4'h5};
    logic [2:0]       in_valid3 = '0;
    logic [2:0]       in_ready3;
    logic [3:0]       out_data3;
    logic             out_valid3;
    logic             out_ready3 = 1'b1;
    logic [1:0]       out_canal3;

    int n_tests = 0;
    int n_fail  = 0;
    logic [5:0] q[$];
    bit m_valid = 1'b0;
    int m_ptr   = 0;

    module_mux_arbitro_rr #(.CANALES(4), .ANCHO(4)) dut (
        .clk(clk), .rst(rst), .modo(modo), .sel(sel), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_canal(out_canal)
    );

    module_mux_arbitro_rr #(.CANALES(3), .ANCHO(4)) dut3 (
        .clk(clk), .rst(rst), .modo(modo3), .sel(sel3), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_canal(out_canal3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // -1 means no grant
    function automatic int model_grant(input logic [1:0] m, input logic [1:0] s,
                                       input logic [3:0] v, input int p);
        if (m == 2'b00) return v[s] ? int'(s) : -1;
        if (m == 2'b01) begin
            for (int i = 0; i < 4; i++) if (v[i]) return i;
            return -1;
        end
        for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        logic [5:0] e;
        bit c;
        if (rst) begin
            check("rst_in_ready", in_ready, 0);
            q.delete();
            m_valid = 1'b0;
            m_ptr = 0;
        end else begin
            check("out_valid", out_valid, m_valid);
            c = !m_valid || out_ready;
            if (m_valid && out_ready) begin
                if (q.size() == 0) check("sb_empty", 1, 0);
                else begin
                    e = q.pop_front();
                    check("sb_data", out_data, e[3:0]);
                    check("sb_canal", out_canal, e[5:4]);
                end
            end
            g = c ? model_grant(modo, sel, in_valid, m_ptr) : -1;
            check("in_ready", in_ready, g >= 0 ? (32'd1 << g) : 0);
            if (g >= 0) begin
                q.push_back({2'(g), in_data[g]});
                m_valid = 1'b1;
                m_ptr = (g + 1) % 4;
            end else if (c) m_valid = 1'b0;
        end
    end

    initial begin
        logic [1:0] c0;
        logic [3:0] d0;
        in_valid = 4'b1111;
        in_data = {4'h4, 4'hA, 4'h2, 4'h1};
        step();
        check("rst_ready_mid", in_ready, 0);
        step();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_canal", out_canal, 0);
        rst = 1'b0;
        modo = MODO_SEL;
        sel = 2'd2;
        out_ready = 1'b1;
        step();
        check("sel_data", out_data, 4'hA);
        check("sel_canal", out_canal, 2);
        check("sel_valid", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        modo = MODO_RR;
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_canal", out_canal, k % 4);
            check("rr_valid", out_valid, 1);
        end
        modo = MODO_PRIO;
        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            step();
            check("prio_canal1", out_canal, 1);
        end
        in_valid = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            step();
            check("prio_canal3", out_canal, 3);
        end
        modo = MODO_RR;
        in_valid = 4'b1111;
        step();
        step();
        out_ready = 1'b0;
        c0 = out_canal;
        d0 = out_data;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_canal", out_canal, c0);
            check("bp_data", out_data, d0);
            check("bp_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        check("bp_resume", out_canal, (c0 + 2'd1));
        out_ready = 1'b0;
        step();
        check("rst_pre_valid", out_valid, 1);
        rst = 1'b1;
        step();
        check("rst_drop_valid", out_valid, 0);
        rst = 1'b0;
        in_valid3 = 3'b111;
        sel3 = 2'd0;
        step();
        check("c3_valid", out_valid3, 1);
        check("c3_canal", out_canal3, 0);
        check("c3_data", out_data3, 4'h5);
        sel3 = 2'd3;
        #1;
        check("c3_noready", in_ready3, 0);
        step();
        check("c3_drop", out_valid3, 0);
        for (int k = 0; k < 300; k++) begin
            modo = 2'($urandom_range(0, 3));
            sel = 2'($urandom_range(0, 3));
            in_valid = 4'($urandom_range(0, 15));
            in_data = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        step();
        step();
        step();
        check("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
